// File: rtl/smsdac_seg_core.sv
// Segmented mismatch-shaping DAC core: 0/1/2-order error-feedback requantiser feeding
// NSEG binary-weighted 3-level segments. Optional LFSR dither: define SMSDAC_DITHER_EN.
module smsdac_seg_core #(
   parameter int DIN_W = 8,
   parameter int NSEG  = 4
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic [DIN_W-1:0]  d_in,
   input  logic [1:0]        ns_order,
   input  logic              ms_en,
   output logic [2*NSEG-1:0] d_out
);
   localparam int SH  = DIN_W - NSEG;
   localparam int W_W = DIN_W + 4;
   localparam int Q_W = NSEG + 2;
   localparam int E_W = SH + 1;

   localparam logic [DIN_W-1:0]      MID_IN = DIN_W'(2**(DIN_W-1));
   localparam logic signed [W_W-1:0] MID_W  = W_W'(2**(DIN_W-1));
   localparam logic signed [W_W-1:0] HALF_S = W_W'(2**(SH-1));
   localparam logic signed [W_W-1:0] EMIN_W = -HALF_S;
   localparam logic signed [W_W-1:0] EMAX_W = HALF_S - W_W'(1);
   localparam logic signed [W_W-1:0] QMAX_W = W_W'(2**NSEG - 1);
   localparam logic signed [W_W-1:0] QMIN_W = -QMAX_W;
   localparam logic signed [Q_W-1:0] ONE_Q  = Q_W'(1);

   // Stage 1 registers
   logic [DIN_W-1:0]      din_q;
   logic [1:0]            ord_q;
   logic                  ms1_q;

   // Stage 2 registers and next state
   logic [1:0]            ord_prev_q;
   logic                  ms2_q;
   logic signed [Q_W-1:0] q_d, q_q;
   logic signed [E_W-1:0] e_d, e1_q, e2_q;

   // Stage 3 registers and next state
   logic [NSEG-1:0]       s_d, s_q;
   logic [2*NSEG-1:0]     code_d, d_out_q;

   // Requantiser datapath
   logic                  ord_chg;
   logic signed [W_W-1:0] u_w, fb_w, w_w, qr_w, ew_w, dith_w;

   // Encoder working variables
   logic signed [Q_W-1:0] enc_r, enc_lim;
   logic                  enc_pos;

`ifdef SMSDAC_DITHER_EN
   localparam logic signed [W_W-1:0] QTR_S = W_W'(2**(SH-2));
   logic [14:0] lfsr_q;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) lfsr_q <= 15'h0001;
      else        lfsr_q <= {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
   end

   assign dith_w = lfsr_q[0] ? QTR_S : -QTR_S;
`else
   assign dith_w = '0;
`endif

   // NOTE: din_q resets to mid-scale (u = 0) so the empty pipeline yields q = 0 and
   // leaves the error registers at zero instead of feeding back a full-scale error.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         din_q <= MID_IN;
         ord_q <= 2'd0;
         ms1_q <= 1'b0;
      end else begin
         din_q <= d_in;
         ord_q <= ns_order;
         ms1_q <= ms_en;
      end
   end

   always_comb begin
      ord_chg = (ord_q != ord_prev_q);
      u_w     = W_W'($signed({1'b0, din_q})) - MID_W;
      if (ord_chg || ord_q == 2'd0) fb_w = u_w;
      else if (ord_q == 2'd1)       fb_w = u_w + W_W'(e1_q);
      else                          fb_w = u_w + (W_W'(e1_q) <<< 1) - W_W'(e2_q);
      w_w  = fb_w + dith_w;
      // Arithmetic shift of (w + S/2) is floor((w + S/2) / S)
      qr_w = (w_w + HALF_S) >>> SH;
      if (qr_w > QMAX_W)      q_d = Q_W'(QMAX_W);
      else if (qr_w < QMIN_W) q_d = Q_W'(QMIN_W);
      else                    q_d = Q_W'(qr_w);
      ew_w = w_w - (W_W'(q_d) <<< SH);
      if (ew_w > EMAX_W)      e_d = E_W'(EMAX_W);
      else if (ew_w < EMIN_W) e_d = E_W'(EMIN_W);
      else                    e_d = E_W'(ew_w);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         q_q        <= '0;
         e1_q       <= '0;
         e2_q       <= '0;
         ord_prev_q <= 2'd0;
         ms2_q      <= 1'b0;
      end else begin
         q_q        <= q_d;
         ms2_q      <= ms1_q;
         ord_prev_q <= ord_q;
         if (ord_chg) begin
            e1_q <= '0;
            e2_q <= '0;
         end else begin
            e1_q <= e_d;
            e2_q <= e1_q;
         end
      end
   end

   // NOTE: enc_r is reassigned per segment; blocking assignment makes each loop
   // iteration see the residual left by the previous one.
   always_comb begin
      enc_r   = q_q;
      enc_lim = '0;
      enc_pos = 1'b0;
      s_d     = s_q;
      code_d  = '0;
      for (int k = 0; k < NSEG; k++) begin
         enc_lim = Q_W'((1 << (NSEG - k)) - 1);
         if (enc_r[0]) begin
            if (enc_r == enc_lim || enc_r == -enc_lim) begin
               enc_pos = ~enc_r[Q_W-1];
            end else if (ms2_q) begin
               enc_pos = ~s_q[k];
               s_d[k]  = ~s_q[k];
            end else begin
               enc_pos = 1'b1;
            end
            code_d[2*k +: 2] = enc_pos ? 2'b10 : 2'b01;
            enc_r = enc_pos ? ((enc_r - ONE_Q) >>> 1) : ((enc_r + ONE_Q) >>> 1);
         end else begin
            enc_r = enc_r >>> 1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         s_q     <= '0;
         d_out_q <= '0;
      end else begin
         s_q     <= s_d;
         d_out_q <= code_d;
      end
   end

   assign d_out = d_out_q;

endmodule

// File: tb/tb_smsdac_seg_core.sv
// Scoreboard bench for smsdac_seg_core (DIN_W=8, NSEG=4): integer reference model feeds
// a queue at stimulus time; a negedge monitor pops and compares when each result is due.
module tb_smsdac_seg_core;
   localparam int DIN_W = 8;
   localparam int NSEG  = 4;
   localparam int S     = 16;
   localparam int QMAX  = 15;

   logic       clk = 1'b0;
   logic       rst_b = 1'b1;
   logic [7:0] d_in;
   logic [1:0] ns_order;
   logic       ms_en;
   logic [7:0] d_out;

   always #5 clk = ~clk;

   smsdac_seg_core #(.DIN_W(DIN_W), .NSEG(NSEG)) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .d_in     (d_in),
      .ns_order (ns_order),
      .ms_en    (ms_en),
      .d_out    (d_out)
   );

   typedef struct {
      logic [7:0] code;
      int         q;
      int         due;
      int         tag;
      int         idx;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   edge_cnt = 0;
   bit   chk_e = 1'b0;
   int   t4_sum = 0;
   int   t4_cnt = 0;

   int            m_e1, m_e2, m_prev_ord;
   logic [NSEG-1:0] m_s;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(string name, logic signed [31:0] act, logic signed [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_cnt, act, exp);
      end
   endtask

   function automatic int fdiv(int a, int b);
      return (a >= 0) ? a / b : -((-a + b - 1) / b);
   endfunction

   function automatic int wsum(logic [7:0] c);
      int acc = 0;
      for (int k = 0; k < NSEG; k++) begin
         if (c[2*k +: 2] == 2'b10)      acc += (1 << k);
         else if (c[2*k +: 2] == 2'b01) acc -= (1 << k);
      end
      return acc;
   endfunction

   task automatic model_reset();
      m_e1 = 0;
      m_e2 = 0;
      m_prev_ord = 0;
      m_s = '0;
   endtask

   task automatic model_step(input int din, input int ord, input bit ms,
                             output logic [7:0] code, output int q);
      int u, w, e, r, c, lim;
      u = din - 128;
      if (ord != m_prev_ord || ord == 0) w = u;
      else if (ord == 1)                 w = u + m_e1;
      else                               w = u + 2 * m_e1 - m_e2;
      q = fdiv(w + S / 2, S);
      if (q > QMAX)  q = QMAX;
      if (q < -QMAX) q = -QMAX;
      e = w - q * S;
      if (e > S / 2 - 1) e = S / 2 - 1;
      if (e < -S / 2)    e = -S / 2;
      if (ord != m_prev_ord) begin
         m_e1 = 0;
         m_e2 = 0;
      end else begin
         m_e2 = m_e1;
         m_e1 = e;
      end
      m_prev_ord = ord;
      r = q;
      code = '0;
      for (int k = 0; k < NSEG; k++) begin
         if (r % 2 == 0) begin
            r = r / 2;
         end else begin
            lim = (1 << (NSEG - k)) - 1;
            if (r == lim || r == -lim) c = (r > 0) ? 1 : -1;
            else if (ms) begin
               c = m_s[k] ? -1 : 1;
               m_s[k] = ~m_s[k];
            end else c = 1;
            code[2*k +: 2] = (c > 0) ? 2'b10 : 2'b01;
            r = (r - c) / 2;
         end
      end
   endtask

   task automatic apply(input logic [7:0] din, input logic [1:0] ord, input bit ms,
                        input int tag, input int idx);
      exp_t x;
      d_in = din;
      ns_order = ord;
      ms_en = ms;
      model_step(int'(din), int'(ord), ms, x.code, x.q);
      x.due = edge_cnt + 3;
      x.tag = tag;
      x.idx = idx;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      exp_t z;
      rst_b = 1'b0;
      d_in = 8'hFF;
      ns_order = 2'd0;
      ms_en = 1'b0;
      #1 check("rst_async", d_out, 0);
      repeat (3) begin
         @(negedge clk);
         check("rst_hold", d_out, 0);
      end
      sb.delete();
      model_reset();
      rst_b = 1'b1;
      z.code = '0;
      z.q = 0;
      z.tag = 1;
      z.idx = 0;
      z.due = edge_cnt + 1;
      sb.push_back(z);
      z.due = edge_cnt + 2;
      sb.push_back(z);
   endtask

   exp_t mon_x;
   int   mon_e;

   always @(negedge clk) begin
      if (rst_b) begin
         while (sb.size() > 0 && sb[0].due <= edge_cnt) begin
            mon_x = sb.pop_front();
            check("d_out", d_out, mon_x.code);
            check("wsum", wsum(d_out), mon_x.q);
            if (mon_x.tag == 4 && mon_x.idx >= 2) begin
               t4_sum += wsum(d_out);
               t4_cnt++;
            end
         end
         if (chk_e) begin
            mon_e = int'(dut.e1_q);
            check("e1_range", (mon_e >= -S / 2 && mon_e <= S / 2), 1);
            mon_e = int'(dut.e2_q);
            check("e2_range", (mon_e >= -S / 2 && mon_e <= S / 2), 1);
         end
      end
   end

   initial begin
      logic [7:0] pat [4];
      logic [7:0] rd;
      logic [1:0] ord;
      pat[0] = 8'h80; pat[1] = 8'h90; pat[2] = 8'hFF; pat[3] = 8'h00;
      d_in = 8'h00;
      ns_order = 2'd0;
      ms_en = 1'b0;
      model_reset();
      #2 do_reset();

      for (int p = 0; p < 4; p++)
         repeat (4) apply(pat[p], 2'd0, 1'b0, 2, 0);

      for (int i = 0; i < 12; i++) apply(8'h90, 2'd0, 1'b1, 3, i);

      repeat (3) apply(8'hFF, 2'd0, 1'b0, 2, 0);
      do_reset();

      for (int i = 0; i < 20; i++) apply(8'h88, 2'd1, 1'b0, 4, i);

      chk_e = 1'b1;
      for (int i = 0; i < 10000; i++) begin
         ord = (i >= 4000 && i < 4200) ? 2'd1 : 2'd2;
         if (i % 50 == 0)      rd = 8'h00;
         else if (i % 50 == 1) rd = 8'hFF;
         else                  rd = 8'($urandom_range(0, 255));
         apply(rd, ord, 1'($urandom % 2), 5, i);
      end
      chk_e = 1'b0;

      for (int i = 0; i < 100; i++) apply(8'hFF, 2'd0, 1'b1, 6, i);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("drain", sb.size(), 0);
      check("t4_mean_x2", 2 * t4_sum, t4_cnt);
      check("s_final", int'(dut.s_q), int'(m_s));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
